// File: rtl/comparador_pkg.sv
// comparador_pkg
// Shared definitions for the threshold comparator:
//   - state_t      : run-tracking FSM states (IDLE, RUN, ALARM)
//   - DEF_WIDTH    : default sample/threshold width
//   - DEF_THRESH   : default threshold loaded at reset (legacy "less than 3")
//   - DEF_RUN_LEN  : default number of consecutive hits that raise the alarm
//   - DEF_CNT_W    : default width of the statistics counters
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_THRESH  = 3;
    localparam int DEF_RUN_LEN = 3;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its maximum value instead of wrapping.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset (q -> 0)
//   clr  in   synchronous clear (q -> 0), has priority over inc
//   inc  in   increment request
//   q    out  CNT_W-bit count
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/comparador_umbral_seq.sv
// comparador_umbral_seq
// Registers a "sample strictly below threshold" flag for every valid sample,
// tracks runs of consecutive below-threshold samples and raises a level alarm
// once RUN_LEN hits in a row have been seen. Idle cycles do not break a run.
//
// Optional statistics: define COMPARADOR_STATS_EN to build saturating hit and
// total counters; without it hit_cnt/total_cnt are constant 0.
//
// Handshake: in_valid qualifies in_data for one cycle, no backpressure.
// out_valid is a one-cycle pulse, one clock after the accepted sample, and
// f is meaningful while out_valid=1 (it holds its last value otherwise).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous clear of FSM and counters (not thr/f/out_valid)
//   thr_load, thr_in  threshold load; a same-cycle sample uses the old threshold
//   in_valid, in_data sample input (unsigned)
//   out_valid, f      registered comparison result
//   alarm             1 while the FSM is in ALARM
//   hit_cnt, total_cnt saturating statistics
//   state_dbg         current FSM state (comparador_pkg::state_t encoding)
module comparador_umbral_seq
    import comparador_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESH_RST = DEF_THRESH,
    parameter int RUN_LEN    = DEF_RUN_LEN,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             thr_load,
    input  logic [WIDTH-1:0] thr_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             f,
    output logic             alarm,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [1:0]       state_dbg
);

    localparam int               RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    logic [WIDTH-1:0] thr;
    logic             hit;
    state_t           state, state_n;
    logic [RUN_W-1:0] run, run_n;

    // Combinational compare against the current (pre-load) threshold.
    assign hit = (in_data < thr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr <= WIDTH'(THRESH_RST);
        end else if (thr_load) begin
            thr <= thr_in;
        end
    end

    // clr deliberately does not affect the flag path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            f         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f <= hit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            run   <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
        end
    end

    // clr wins over a coincident sample: the sample is flagged but not tracked.
    always_comb begin
        state_n = state;
        run_n   = run;
        if (clr) begin
            state_n = IDLE;
            run_n   = '0;
        end else if (in_valid) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_n = RUN;
                        run_n   = RUN_W'(1);
                    end
                end
                RUN: begin
                    if (hit) begin
                        run_n = run + 1'b1;
                        if ((run + 1'b1) == RUN_MAX) begin
                            state_n = ALARM;
                        end
                    end else begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                end
                ALARM: begin
                    if (hit) begin
                        run_n = RUN_MAX;
                    end else begin
                        state_n = IDLE;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    run_n   = '0;
                end
            endcase
        end
    end

    // State is registered on the same edge as out_valid, so alarm lines up
    // with the flag of the RUN_LEN-th consecutive hit.
    assign alarm     = (state == ALARM);
    assign state_dbg = state;

`ifdef COMPARADOR_STATS_EN
    logic inc_total, inc_hit;

    assign inc_total = in_valid;
    assign inc_hit   = in_valid && hit;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_hit),
        .q   (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_total),
        .q   (total_cnt)
    );
`else
    assign hit_cnt   = '0;
    assign total_cnt = '0;
`endif

endmodule

// File: doc/comparador_umbral_seq.md
# comparador_umbral_seq

Sequential, parametrised successor of the 3-bit "input less than 3" combinational detector. Each valid input sample is compared against a run-time-loadable threshold, and the flag F is registered. The block also tracks consecutive below-threshold runs through a small FSM and, optionally, keeps saturating hit and total counters. It sits between a sampled data source and the control and monitoring logic that consumes the flag and the alarm.

## Interface
- WIDTH, 3: sample and threshold width in bits (≥1).
- THRESH_RST, 3: threshold value loaded at reset (the legacy "less than 3" behaviour).
- RUN_LEN, 3: number of consecutive hits needed to raise the alarm (≥2).
- CNT_W, 8: width of the statistics counters.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of the run FSM and the counters.
- thr_load  in  1  loads thr_in into the threshold register.
- thr_in  in  WIDTH  new threshold value.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  sample to compare, unsigned.
- out_valid  out  1  f is valid; one-cycle pulse per accepted sample.
- f  out  1  1 when the sample is strictly less than the threshold.
- alarm  out  1  level signal; 1 while the FSM is in ALARM.
- hit_cnt  out  CNT_W  number of samples with f=1 (saturating).
- total_cnt  out  CNT_W  number of accepted samples (saturating).

## Operation
- Compare: hit = (in_data < thr), unsigned. Sample equal to the threshold is a miss.
- A threshold of 0 makes every sample a miss.
- The threshold register is loaded on thr_load.
- A sample in the same cycle as thr_load is compared against the old threshold.
- Run FSM:
  - IDLE: on a hit go to RUN with run=1; misses stay in IDLE.
  - RUN: a hit increments run; when run reaches RUN_LEN go to ALARM. A miss returns to IDLE with run=0.
  - ALARM: further hits hold ALARM, and run saturates at RUN_LEN. A miss returns to IDLE.
  - Cycles without in_valid leave the state and run unchanged (gaps do not break a run).
- clr: forces IDLE, run=0 and both counters to 0. It does not touch the threshold, f or out_valid.
- clr together with in_valid:
  - the sample still produces f and out_valid;
  - clr wins, so the sample is not counted and does not advance the FSM.
- Counters increment on accepted samples and saturate at 2^CNT_W−1, with no wrap.

## Timing
- Reset values: out_valid=0, f=0, alarm=0, hit_cnt=0, total_cnt=0, state=IDLE, run=0, thr=THRESH_RST.
- Latency:
  - f and out_valid are registered one cycle after the in_valid edge.
  - alarm rises in the same cycle as the out_valid of the RUN_LEN-th consecutive hit.
  - Counters update in the same cycle as out_valid.
- No backpressure; one sample can be accepted every cycle.
- f holds its last value while out_valid=0.
- rst asserted mid-run returns everything to reset values immediately (asynchronously); the first sample after deassertion is treated as fresh.

## Configuration
- COMPARADOR_STATS_EN defined: hit_cnt and total_cnt are implemented as described.
- COMPARADOR_STATS_EN not defined: no counter flops are built; hit_cnt and total_cnt are tied to 0. The FSM, f and alarm are unchanged.

## Structure
- Package comparador_pkg holds:
  - the state enum (IDLE, RUN, ALARM);
  - the default parameter constants (WIDTH, THRESH_RST, RUN_LEN, CNT_W).
- Sub-module sat_counter is instantiated twice (hits and total).
  - Parameter: CNT_W.
  - Ports: clk, rst, clr, inc, q.
  - Increments on inc, holds at the maximum value.

## Test plan
All scenarios use WIDTH=3, THRESH_RST=3, RUN_LEN=3, CNT_W=4.
- Reset, then sweep in_data 0..7 one per cycle -> f=1,1,1,0,0,0,0,0; out_valid one cycle after each sample; total_cnt=8, hit_cnt=3.
- thr_load with thr_in=5 in the same cycle as in_data=4, then in_data=4 again -> first f=0 (old threshold 3), second f=1.
- Samples 1,0,2 with an idle cycle between 0 and 2 -> alarm=1 at the third out_valid; next sample 6 -> alarm=0, FSM in IDLE.
- 20 consecutive samples of 0 -> hit_cnt and total_cnt stop at 15; alarm stays 1.
- clr together with in_valid and in_data=1 while in ALARM -> f=1 and out_valid=1; alarm=0, counters=0, and the sample is not counted.
- rst asserted while in RUN with run=2 -> all outputs 0 immediately, thr=3; after release, samples 0,0,0 raise alarm only on the third.
